key_dac_ctrl: RTL

- Consumes the debounced press/release events (flag + state pairs) from the key debouncers for the UP, DN and CH keys.
- Maintains two 12-bit DAC setpoints, A and B, and steps the selected one on each press, with long-press auto-repeat.
- Issues single-cycle update requests, one channel at a time, to the TLC5618 serial driver downstream and respects its busy signal.

---
 rtl/key_dac_pkg.sv | 19 +
 rtl/key_repeat_timer.sv | 37 +++
 rtl/key_dac_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/key_dac_pkg.sv
// Shared types and constants for the key-driven dual DAC setpoint controller.
package key_dac_pkg;

  localparam int unsigned DW_DEF        = 12;
  localparam int unsigned STEP_DEF      = 16;
  localparam int unsigned CODE_INIT_DEF = 2048;
  localparam int unsigned HOLD_CYC_DEF  = 25_000_000;
  localparam int unsigned RPT_CYC_DEF   = 5_000_000;
  localparam int unsigned CODE_MAX      = (1 << DW_DEF) - 1;

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StHoldUp = 5'b00010,
    StHoldDn = 5'b00100,
    StRptUp  = 5'b01000,
    StRptDn  = 5'b10000
  } key_fsm_e;

endpackage

// File: rtl/key_repeat_timer.sv
// Hold / auto-repeat interval timer shared by both step directions.
module key_repeat_timer #(
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned RPT_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  input  logic phase,
  output logic step
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] limit;

  always_comb begin
    limit = phase ? 32'(RPT_CYC - 1) : 32'(HOLD_CYC - 1);
    step  = run && (cnt_q >= limit);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      // Wrapping at the step also starts the next interval from zero.
      cnt_d = step ? '0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_dac_ctrl.sv
// UP/DN/CH key handling for two DAC setpoints with auto-repeat and
// single-cycle update requests towards the serial DAC driver.
module key_dac_ctrl
  import key_dac_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned CODE_INIT = CODE_INIT_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
  parameter int unsigned RPT_CYC   = RPT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_flag,
  input  logic          up_state,
  input  logic          dn_flag,
  input  logic          dn_state,
  input  logic          ch_flag,
  input  logic          ch_state,
  input  logic          dac_busy,
  output logic          dac_req,
  output logic          dac_chan,
  output logic [DW-1:0] dac_code,
  output logic          sel_chan
);

  localparam logic [DW-1:0] CodeMax  = '1;
  localparam logic [DW-1:0] CodeInit = DW'(CODE_INIT);
  localparam logic [DW:0]   StepW    = (DW + 1)'(STEP);

  logic up_press, up_rel, dn_press, dn_rel, ch_press;

  key_fsm_e state_q, state_d;
  logic     step_up, step_dn;
  logic     tmr_clear, tmr_run, tmr_phase, tmr_step;

  logic [DW-1:0] code_a_q, code_a_d, code_b_q, code_b_d;
  logic [DW-1:0] code_cur, code_up, code_dn, code_new;
  logic [DW:0]   code_sum;
  logic          code_wr_a, code_wr_b;

  logic          sel_q, sel_d;
  logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic          req_ok, req_a, req_b;
  logic          dac_req_q, dac_req_d, dac_chan_q, dac_chan_d;
  logic [DW-1:0] dac_code_q, dac_code_d;

  // A flag with the key low is a press; with the key high it is a release.
  assign up_press = up_flag & ~up_state;
  assign up_rel   = up_flag & up_state;
  assign dn_press = dn_flag & ~dn_state;
  assign dn_rel   = dn_flag & dn_state;
  assign ch_press = ch_flag & ~ch_state;

  assign tmr_clear = (state_q == StIdle);
  assign tmr_run   = (state_q != StIdle);
  assign tmr_phase = (state_q == StRptUp) || (state_q == StRptDn);

  key_repeat_timer #(
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tmr_clear),
    .run  (tmr_run),
    .phase(tmr_phase),
    .step (tmr_step)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (up_press && !dn_press) begin
          state_d = StHoldUp;
        end else if (dn_press && !up_press) begin
          state_d = StHoldDn;
        end
      end
      StHoldUp: begin
        if (up_rel) begin
          state_d = StIdle;
        end else if (tmr_step) begin
          state_d = StRptUp;
        end
      end
      StHoldDn: begin
        if (dn_rel) begin
          state_d = StIdle;
        end else if (tmr_step) begin
          state_d = StRptDn;
        end
      end
      StRptUp: begin
        if (up_rel) state_d = StIdle;
      end
      StRptDn: begin
        if (dn_rel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Release wins over a step falling due on the same edge.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    unique case (state_q)
      StIdle: begin
        step_up = up_press && !dn_press;
        step_dn = dn_press && !up_press;
      end
      StHoldUp, StRptUp: step_up = tmr_step && !up_rel;
      StHoldDn, StRptDn: step_dn = tmr_step && !dn_rel;
      default: ;
    endcase
  end

  // Saturating step on the currently selected channel.
  always_comb begin
    code_cur  = sel_q ? code_b_q : code_a_q;
    code_sum  = {1'b0, code_cur} + StepW;
    code_up   = (code_sum > {1'b0, CodeMax}) ? CodeMax : code_sum[DW-1:0];
    code_dn   = ({1'b0, code_cur} < StepW) ? '0 : code_cur - StepW[DW-1:0];
    code_new  = step_up ? code_up : code_dn;
    code_wr_a = (step_up || step_dn) && (code_new != code_cur) && !sel_q;
    code_wr_b = (step_up || step_dn) && (code_new != code_cur) && sel_q;
    code_a_d  = code_wr_a ? code_new : code_a_q;
    code_b_d  = code_wr_b ? code_new : code_b_q;
    sel_d     = sel_q ^ ch_press;
  end

  // Requests carry the pre-step code; a coincident step re-arms pend.
  always_comb begin
    req_ok     = !dac_busy && !dac_req_q && (pend_a_q || pend_b_q);
    req_a      = req_ok && pend_a_q;
    req_b      = req_ok && !pend_a_q;
    pend_a_d   = (pend_a_q && !req_a) || code_wr_a;
    pend_b_d   = (pend_b_q && !req_b) || code_wr_b;
    dac_req_d  = req_ok;
    dac_chan_d = dac_chan_q;
    dac_code_d = dac_code_q;
    if (req_a) begin
      dac_chan_d = 1'b0;
      dac_code_d = code_a_q;
    end else if (req_b) begin
      dac_chan_d = 1'b1;
      dac_code_d = code_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      code_a_q   <= CodeInit;
      code_b_q   <= CodeInit;
      sel_q      <= 1'b0;
      pend_a_q   <= 1'b1;
      pend_b_q   <= 1'b1;
      dac_req_q  <= 1'b0;
      dac_chan_q <= 1'b0;
      dac_code_q <= '0;
    end else begin
      code_a_q   <= code_a_d;
      code_b_q   <= code_b_d;
      sel_q      <= sel_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      dac_req_q  <= dac_req_d;
      dac_chan_q <= dac_chan_d;
      dac_code_q <= dac_code_d;
    end
  end

  assign dac_req  = dac_req_q;
  assign dac_chan = dac_chan_q;
  assign dac_code = dac_code_q;
  assign sel_chan = sel_q;

endmodule
